// File: rtl/bus_pkg.sv
// +----------------------------------------------------------------------------+
// | bus_pkg : shared widths, beat type and skid state encoding for the bus mux |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package bus_pkg;

  localparam int BUS_W    = 9;
  localparam int BUS_SELW = 4;
  localparam int BUS_NCH  = 10;

  typedef struct packed {
    logic             err;
    logic [BUS_W-1:0] data;
  } bus_beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_mux_sel.sv
// +----------------------------------------------------------------------------+
// | bus_mux_sel : combinational N:1 channel extractor with select range check  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bus_mux_sel
  import bus_pkg::*;
#(
  parameter int N  = BUS_NCH,
  parameter int W  = BUS_W,
  parameter int SW = BUS_SELW
) (
  input  logic [N*W-1:0] i_data,
  input  logic [SW-1:0]  i_sel,
  output logic [W-1:0]   o_data,
  output logic           o_err
);

  // Any select not matching a populated channel falls through as an error beat.
  always_comb begin
    o_data = '0;
    o_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (i_sel == SW'(k)) begin
        o_data = i_data[k*W +: W];
        o_err  = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_mux_pipe.sv
// +----------------------------------------------------------------------------+
// | bus_mux_pipe : N:1 W-bit bus mux, registered output, valid/ready, beat cnt |
// | Optional one-entry skid buffer with registered ready: BUS_MUX_SKID_EN      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bus_mux_pipe
  import bus_pkg::*;
#(
  parameter int N  = BUS_NCH,
  parameter int W  = BUS_W,
  parameter int SW = BUS_SELW,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  beat_cnt
);

  if (N < 2 || N > 16 || (1 << SW) < N) begin : g_param_check
    $fatal(1, "bus_mux_pipe: illegal N/SW combination");
  end

  logic [W-1:0]  w_sel_data;
  logic          w_sel_err;
  logic          w_accept;
  logic          w_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_err;
  logic [CW-1:0] r_beat_cnt;

  bus_mux_sel #(.N(N), .W(W), .SW(SW)) u_sel (
    .i_data (in_data),
    .i_sel  (sel),
    .o_data (w_sel_data),
    .o_err  (w_sel_err)
  );

`ifdef BUS_MUX_SKID_EN
  skid_state_t r_state;
  skid_state_t w_state_nxt;
  logic        r_in_ready;
  logic [W-1:0] r_skid_data;
  logic        r_skid_err;
  logic        w_load_in;
  logic        w_load_skid;
  logic        w_load_from_skid;

  assign w_accept = in_valid && r_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL2);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_in        = 1'b0;
    w_load_skid      = 1'b0;
    w_load_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL1;
          w_load_in   = 1'b1;
        end
      end
      ST_FULL1: begin
        if (w_accept && !out_ready) begin
          w_state_nxt = ST_FULL2;
          w_load_skid = 1'b1;
        end else if (w_accept) begin
          w_load_in = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (out_ready) begin
          w_state_nxt      = ST_FULL1;
          w_load_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_in) begin
        r_out_data <= w_sel_data;
        r_out_err  <= w_sel_err;
      end else if (w_load_from_skid) begin
        r_out_data <= r_skid_data;
        r_out_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_err  <= w_sel_err;
      end
    end
  end

  assign w_out_valid = (r_state != ST_EMPTY);
  assign in_ready    = r_in_ready;
`else
  logic r_out_valid;

  // Ready looks through the output register so a draining beat frees the slot.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_err   <= w_sel_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign w_out_valid = r_out_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_out_valid && out_ready) begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign beat_cnt  = r_beat_cnt;

endmodule

`default_nettype wire
